// File: rtl/display_page_scheduler_pkg.sv
// Shared constants for the seven-segment debug display: page numbers and the
// default timing parameters used by the board top and the benches.
package display_page_scheduler_pkg;

  localparam int unsigned DIV_HALF_DEFAULT   = 262144;   // 100 MHz -> 190.7 Hz scan clock
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;  // 10 ms at 100 MHz

  typedef enum logic [1:0] {
    PAGE_PC    = 2'd0,
    PAGE_INSTR = 2'd1,
    PAGE_REG   = 2'd2,
    PAGE_ALU   = 2'd3
  } page_e;

endpackage

// File: rtl/display_page_scheduler_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted press. Reusable for any raw active-high button.
module display_page_scheduler_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             commit;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d    = cnt_q + CNT_W'(1);
    stable_d = stable_q;
    press_d  = 1'b0;
    commit   = (sync_q[1] != stable_q) && (cnt_q == CNT_LAST);
    // Any return to the accepted level restarts the stability window.
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (commit) begin
      cnt_d    = '0;
      stable_d = sync_q[1];
      press_d  = sync_q[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments and clear asynchronously.
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/display_page_scheduler.sv
// Scan-clock divider, frame counter, debug page selection and frame-synchronous
// latching of the word shown on the 4-digit seven-segment scanner.
module display_page_scheduler
  import display_page_scheduler_pkg::*;
#(
  parameter int unsigned DIV_HALF   = DIV_HALF_DEFAULT,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        clr,
  input  logic        btn_page,
  input  logic        sw_direct,
  input  logic [1:0]  sw_page,
  input  logic [15:0] page0_data,
  input  logic [15:0] page1_data,
  input  logic [15:0] page2_data,
  input  logic [15:0] page3_data,
  output logic        CLK_190hz,
  output logic [15:0] disp_data,
  output logic        disp_en,
  output logic [1:0]  page
);

  localparam int unsigned DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             scan_clk_q, scan_clk_d;
  logic [1:0]       frame_cnt_q, frame_cnt_d;
  page_e            page_q, page_d;
  logic             page_chg_q, page_chg_d;
  logic [15:0]      disp_data_q, disp_data_d;
  logic             disp_en_q, disp_en_d;
  logic [1:0]       swd_sync_q;
  logic [1:0]       swp_meta_q, swp_sync_q;
  logic             press, div_wrap, scan_tick, frame_end;
  logic [15:0]      page_word;

  display_page_scheduler_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (CLK),
    .rst_n  (clr),
    .btn_i  (btn_page),
    .press_o(press)
  );

  always_comb begin
    div_wrap    = (div_cnt_q == DIV_LAST);
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    scan_clk_d  = div_wrap ? ~scan_clk_q : scan_clk_q;
    scan_tick   = div_wrap && !scan_clk_q;
    frame_end   = scan_tick && (frame_cnt_q == 2'd3);
    frame_cnt_d = scan_tick ? frame_cnt_q + 2'd1 : frame_cnt_q;

    // Direct switches override the button entirely.
    page_d = page_q;
    if (swd_sync_q[1]) begin
      page_d = page_e'(swp_sync_q);
    end else if (press) begin
      page_d = page_e'(page_q + 2'd1);
    end
    page_chg_d = (page_d != page_q);

    page_word = page0_data;
    case (page_q)
      PAGE_INSTR: page_word = page1_data;
      PAGE_REG:   page_word = page2_data;
      PAGE_ALU:   page_word = page3_data;
      default:    page_word = page0_data;
    endcase

    // Reload only at frame boundaries or right after a page switch, so digits never tear.
    disp_data_d = (frame_end || page_chg_q) ? page_word : disp_data_q;
    disp_en_d   = disp_en_q || frame_end;
  end

  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      div_cnt_q   <= '0;
      scan_clk_q  <= 1'b0;
      frame_cnt_q <= '0;
      page_q      <= PAGE_PC;
      page_chg_q  <= 1'b0;
      disp_data_q <= '0;
      disp_en_q   <= 1'b0;
      swd_sync_q  <= '0;
      swp_meta_q  <= '0;
      swp_sync_q  <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      scan_clk_q  <= scan_clk_d;
      frame_cnt_q <= frame_cnt_d;
      page_q      <= page_d;
      page_chg_q  <= page_chg_d;
      disp_data_q <= disp_data_d;
      disp_en_q   <= disp_en_d;
      swd_sync_q  <= {swd_sync_q[0], sw_direct};
      swp_meta_q  <= sw_page;
      swp_sync_q  <= swp_meta_q;
    end
  end

  assign CLK_190hz = scan_clk_q;
  assign disp_data = disp_data_q;
  assign disp_en   = disp_en_q;
  assign page      = page_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Scoreboard bench for display_page_scheduler: a timeline-based reference model
// predicts every cycle's outputs; a monitor compares them on the falling edge.
module tb_display_page_scheduler;

  localparam int DH    = 4;
  localparam int DEB   = 8;
  localparam int FRAME = 8 * DH;

  logic        CLK = 1'b0;
  logic        clr = 1'b0;
  logic        btn_page = 1'b0;
  logic        sw_direct = 1'b0;
  logic [1:0]  sw_page = 2'd0;
  logic [15:0] pdata [4];
  logic        CLK_190hz;
  logic [15:0] disp_data;
  logic        disp_en;
  logic [1:0]  page;

  display_page_scheduler #(
    .DIV_HALF  (DH),
    .DEB_CYCLES(DEB)
  ) dut (
    .CLK       (CLK),
    .clr       (clr),
    .btn_page  (btn_page),
    .sw_direct (sw_direct),
    .sw_page   (sw_page),
    .page0_data(pdata[0]),
    .page1_data(pdata[1]),
    .page2_data(pdata[2]),
    .page3_data(pdata[3]),
    .CLK_190hz (CLK_190hz),
    .disp_data (disp_data),
    .disp_en   (disp_en),
    .page      (page)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        clk190;
    logic        en;
    logic [1:0]  pg;
    logic [15:0] dd;
  } snap_t;

  snap_t       exp_q[$];
  snap_t       mon_e;
  int          n_m = 0;          // rising edges since reset release
  logic        acc_m = 1'b0;     // accepted button level
  logic        press_m = 1'b0;   // press acts on this edge
  logic [1:0]  page_m = 2'd0;
  logic        chg_m = 1'b0;
  logic [15:0] dd_m = 16'd0;
  logic        en_m = 1'b0;
  logic        btn_h[$];
  logic        swd_h[$];
  logic [1:0]  swp_h[$];
  logic        win[$];

  task automatic model_reset();
    n_m = 0; acc_m = 1'b0; press_m = 1'b0; page_m = 2'd0; chg_m = 1'b0;
    dd_m = 16'd0; en_m = 1'b0;
    btn_h = '{1'b0, 1'b0};
    swd_h = '{1'b0, 1'b0};
    swp_h = '{2'd0, 2'd0};
    win.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    logic       bs, ds;
    logic [1:0] ps, pn;
    logic       fe, all_diff, rise;
    // Inputs are seen two edges after being sampled.
    bs = btn_h.pop_front(); btn_h.push_back(btn_page);
    ds = swd_h.pop_front(); swd_h.push_back(sw_direct);
    ps = swp_h.pop_front(); swp_h.push_back(sw_page);
    n_m++;
    fe = ((n_m % FRAME) == 7 * DH);
    if (ds) pn = ps;
    else if (press_m) pn = page_m + 2'd1;
    else pn = page_m;
    if (fe || chg_m) dd_m = pdata[page_m];
    if (fe) en_m = 1'b1;
    chg_m  = (pn != page_m);
    page_m = pn;
    // Accept a new level once the last DEB synchronised samples all disagree with the old one.
    win.push_back(bs);
    if (win.size() > DEB) void'(win.pop_front());
    all_diff = (win.size() == DEB);
    foreach (win[i]) if (win[i] == acc_m) all_diff = 1'b0;
    rise = 1'b0;
    if (all_diff) begin
      acc_m = ~acc_m;
      rise  = acc_m;
    end
    press_m = rise;
    exp_q.push_back('{clk190: 1'((n_m / DH) % 2), en: en_m, pg: page_m, dd: dd_m});
  endtask

  always @(posedge CLK or negedge clr) begin
    if (!clr) model_reset();
    else model_step();
  end

  always @(negedge CLK) begin
    if (clr && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_scan_clk", CLK_190hz, mon_e.clk190);
      check("sb_disp_en", disp_en, mon_e.en);
      check("sb_page", page, mon_e.pg);
      check("sb_disp_data", disp_data, mon_e.dd);
    end
  end

  // ---------------- stimulus helpers ----------------
  int         pg_steps = 0;
  logic [1:0] pg_prev = 2'd0;

  task automatic hold(input int cyc);
    repeat (cyc) begin
      @(negedge CLK);
      if (page !== pg_prev) pg_steps++;
      pg_prev = page;
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int c;
    c = 0;
    while ((n_m % FRAME) != ph && c < 2 * FRAME) begin
      @(negedge CLK);
      c++;
    end
    check(name, (c < 2 * FRAME), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int unsigned sel;
    pdata[0] = 16'hA5A5; pdata[1] = 16'hC0DE; pdata[2] = 16'h5A5A; pdata[3] = 16'hBEEF;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_scan_clk", CLK_190hz, 1'b0);
    check("rst_disp_data", disp_data, 16'h0);
    check("rst_disp_en", disp_en, 1'b0);
    check("rst_page", page, 2'd0);
    #2 clr = 1'b1;

    // First frame_end after 28 edges enables the display with page 0
    c = 0;
    while (disp_en !== 1'b1 && c < 100) begin
      @(negedge CLK);
      c++;
    end
    check("first_frame_end_edge", c, 28);
    check("first_frame_data", disp_data, 16'hA5A5);

    // Scan clock period
    c = 0;
    while (CLK_190hz !== 1'b0 && c < 20) begin @(negedge CLK); c++; end
    c = 0;
    while (CLK_190hz !== 1'b1 && c < 20) begin @(negedge CLK); c++; end
    c = 0;
    while (CLK_190hz !== 1'b0 && c < 20) begin @(negedge CLK); c++; end
    while (CLK_190hz !== 1'b1 && c < 40) begin @(negedge CLK); c++; end
    check("scan_clk_period", c, 8);

    // Bouncy press held 20 cycles: a single advance 0 -> 1
    pg_prev = page; pg_steps = 0;
    repeat (3) begin
      btn_page = 1'b1; hold(1);
      btn_page = 1'b0; hold(1);
    end
    btn_page = 1'b1; hold(20);
    btn_page = 1'b0; hold(20);
    check("bounce_steps", pg_steps, 1);
    check("bounce_page", page, 2'd1);
    check("bounce_data", disp_data, 16'hC0DE);

    // Advance to page 3, then four clean presses wrap through 0,1,2,3
    repeat (2) begin
      btn_page = 1'b1; hold(14);
      btn_page = 1'b0; hold(14);
    end
    check("pre_wrap_page", page, 2'd3);
    for (int i = 0; i < 4; i++) begin
      pg_steps = 0;
      btn_page = 1'b1; hold(14);
      check("press_page", page, i);
      btn_page = 1'b0; hold(14);
      check("press_release_steps", pg_steps, 1);
    end

    // Direct switches override a held button
    btn_page = 1'b1; sw_direct = 1'b1; sw_page = 2'd2;
    hold(14);
    check("direct_page", page, 2'd2);
    btn_page = 1'b0; hold(14);
    check("direct_btn_ignored", page, 2'd2);
    sw_direct = 1'b0; hold(14);
    check("direct_off_hold", page, 2'd2);

    // Data change mid-frame shows only at the next frame_end
    sw_direct = 1'b1; sw_page = 2'd0; hold(6);
    sw_direct = 1'b0; hold(6);
    check("page0_select", page, 2'd0);
    check("page0_old_data", disp_data, 16'hA5A5);
    wait_phase(30, "wait_after_frame");
    pdata[0] = 16'h1234;
    hold(10);
    check("midframe_hold", disp_data, 16'hA5A5);
    wait_phase(28, "wait_frame_end");
    check("frame_end_update", disp_data, 16'h1234);

    // Asynchronous reset mid-frame on page 3
    sw_direct = 1'b1; sw_page = 2'd3; hold(6);
    sw_direct = 1'b0; hold(4);
    check("pre_reset_page", page, 2'd3);
    wait_phase(12, "wait_midframe");
    @(posedge CLK);
    #3 clr = 1'b0;
    #1;
    check("async_rst_scan_clk", CLK_190hz, 1'b0);
    check("async_rst_disp_data", disp_data, 16'h0);
    check("async_rst_disp_en", disp_en, 1'b0);
    check("async_rst_page", page, 2'd0);
    @(negedge CLK);
    #2 clr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      check("restart_scan_phase", CLK_190hz, (i == 4));
    end
    check("restart_disp_en", disp_en, 1'b0);
    pg_prev = page;

    // Randomised traffic against the model
    for (int it = 0; it < 250; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        btn_page = ~btn_page;
        hold($urandom_range(1, 16));
      end else if (sel < 8) begin
        sw_direct = 1'($urandom_range(0, 1));
        sw_page   = 2'($urandom_range(0, 3));
        hold($urandom_range(1, 8));
      end else begin
        pdata[2'($urandom_range(0, 3))] = 16'($urandom);
        hold($urandom_range(1, 8));
      end
    end
    hold(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
